gb_mbc_bank_ctrl: RTL and testbench

Parametrised bank-register controller for Game Boy cartridge mappers. It generalises the fixed single-mapper path to a configurable ROM/RAM bank width and two register modes: MBC5-style and MBC1-style. It sits inside mappers beside the camera mapper and drives the ROM and RAM address buses, RAM enable and rumble. It captures CPU register writes through a ce-qualified edge detector and supports savestate load and readback.

---
 rtl/gb_mbc_bank_ctrl_pkg.sv | 23 ++
 rtl/gb_mbc_bank_ctrl_if.sv | 14 +
 rtl/gb_mbc_bank_ctrl_wr_detect.sv | 45 ++++
 rtl/gb_mbc_bank_ctrl.sv | 126 ++++++++++++
 tb/tb_gb_mbc_bank_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_mbc_bank_ctrl_pkg.sv
// Shared constants for the Game Boy mapper bank-register controller:
// register-map modes, CPU write region codes, savestate field offsets.
package gb_mbc_pkg;

  localparam int MODE_MBC5 = 0;
  localparam int MODE_MBC1 = 1;

  // cart_addr[14:13] selects which bank register a CPU write targets
  typedef enum logic [1:0] {
    REG_RAMEN = 2'b00,
    REG_ROMB  = 2'b01,
    REG_RAMB  = 2'b10,
    REG_MODE  = 2'b11
  } reg_region_e;

  localparam int SS_ROMB_LSB  = 0;
  localparam int SS_RAMB_LSB  = 16;
  localparam int SS_RAMEN_BIT = 24;
  localparam int SS_MODE_BIT  = 25;

  localparam logic [3:0] RAMEN_KEY = 4'hA;

endpackage

// File: rtl/gb_mbc_bank_ctrl_if.sv
// CPU-side cartridge bus as seen by a mapper. The CPU (master) drives
// everything; the mapper (slave) only observes.
interface gb_mbc_bank_ctrl_if;

  logic        ce;
  logic [14:0] cart_addr;
  logic        cart_a15;
  logic        cart_wr;
  logic [7:0]  cart_di;

  modport master (output ce, cart_addr, cart_a15, cart_wr, cart_di);
  modport slave  (input  ce, cart_addr, cart_a15, cart_wr, cart_di);

endinterface

// File: rtl/gb_mbc_bank_ctrl_wr_detect.sv
// CPU register-write edge detector shared by mapper implementations.
//
// Write semantics: cart_wr is a level that may be held across many ce
// cycles. A commit fires on the first ce cycle that sees cart_wr high
// after it was seen low, and only when en (register space) is high.
// wr_ack is the registered commit, one cycle later. clear (savestate load)
// blocks the commit and forgets the seen-high state. After reset the
// detector is disarmed until it has seen cart_wr low on a ce cycle, so a
// strobe still held across reset release cannot commit.
module gb_mbc_wr_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic wr,
  input  logic en,
  input  logic clear,
  output logic commit,
  output logic wr_ack
);

  logic wr_q;
  logic armed;

  assign commit = ce & wr & ~wr_q & armed & en & ~clear;

  // Track the strobe level per ce, the armed flag, and the delayed ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      armed  <= 1'b0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= commit;
      if (clear) begin
        wr_q <= 1'b0;
      end else if (ce) begin
        wr_q <= wr;
      end
      if (ce & ~wr) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_mbc_bank_ctrl.sv
// Bank-register controller for Game Boy cartridge mappers. Captures CPU
// register writes, holds ROM/RAM bank, RAM enable and bank mode, and maps
// CPU addresses onto ROM and cart-RAM byte addresses. Supports MBC5-style
// and MBC1-style register maps plus savestate load/readback.
module gb_mbc_bank_ctrl
  import gb_mbc_pkg::*;
#(
  parameter int ROM_BANK_W = 9,
  parameter int RAM_BANK_W = 4,
  parameter int MODE       = 0,
  parameter int RUMBLE     = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  gb_mbc_bank_ctrl_if.slave       bus,
  input  logic [ROM_BANK_W-1:0]   rom_mask,
  input  logic [RAM_BANK_W-1:0]   ram_mask,
  input  logic                    has_ram,
  input  logic                    savestate_load,
  input  logic [31:0]             savestate_data,
  output logic [31:0]             savestate_back,
  output logic [14+ROM_BANK_W-1:0] mbc_addr,
  output logic [13+RAM_BANK_W-1:0] cram_addr,
  output logic                    ram_enabled,
  output logic                    rumbling,
  output logic                    wr_ack
);

  logic                  ram_en, bank_mode;
  logic                  en_next, mode_next;
  logic [ROM_BANK_W-1:0] rom_bank, rom_next;
  logic [RAM_BANK_W-1:0] ram_bank, ram_next;
  logic                  commit;
  reg_region_e           region;
  logic [15:0]           di16, low5_16, rb16;
  logic [15:0]           lo16, hi16, rom_sel16;
  logic [7:0]            rb8;
  logic [1:0]            bank2;
  logic                  unused_ss;

  assign region    = reg_region_e'(bus.cart_addr[14:13]);
  assign di16      = {8'h00, bus.cart_di};
  assign low5_16   = {11'h000, (bus.cart_di[4:0] == 5'd0) ? 5'd1 : bus.cart_di[4:0]};
  assign rb16      = 16'(rom_bank);
  assign bank2     = ram_bank[1:0];
  assign unused_ss = &{1'b0, savestate_data[31:26]};

  gb_mbc_wr_detect u_wr_detect (
    .clk    (clk_sys),
    .rst_n  (reset_n),
    .ce     (bus.ce),
    .wr     (bus.cart_wr),
    .en     (~bus.cart_a15),
    .clear  (savestate_load),
    .commit (commit),
    .wr_ack (wr_ack)
  );

  // Decode the register write that would take effect on a commit
  always_comb begin
    rom_next  = rom_bank;
    ram_next  = ram_bank;
    en_next   = ram_en;
    mode_next = bank_mode;
    case (region)
      REG_RAMEN: en_next = (bus.cart_di[3:0] == RAMEN_KEY);
      REG_ROMB: begin
        for (int i = 0; i < ROM_BANK_W; i++) begin
          if (MODE == MODE_MBC1) begin
            if (i < 5) rom_next[i] = low5_16[i];
          end else if (!bus.cart_addr[12]) begin
            if (i < 8) rom_next[i] = di16[i];
          end else begin
            if (i == 8) rom_next[i] = bus.cart_di[0];
          end
        end
      end
      REG_RAMB: begin
        for (int i = 0; i < RAM_BANK_W; i++) begin
          if (MODE != MODE_MBC1 || i < 2) ram_next[i] = bus.cart_di[i];
        end
      end
      REG_MODE: begin
        if (MODE == MODE_MBC1) mode_next = bus.cart_di[0];
      end
    endcase
  end

  // Bank registers: savestate load wins over a coincident CPU commit
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_bank  <= ROM_BANK_W'(1);
      ram_bank  <= '0;
      ram_en    <= 1'b0;
      bank_mode <= 1'b0;
    end else if (savestate_load) begin
      rom_bank  <= ROM_BANK_W'(savestate_data[SS_ROMB_LSB +: 16]);
      ram_bank  <= RAM_BANK_W'(savestate_data[SS_RAMB_LSB +: 8]);
      ram_en    <= savestate_data[SS_RAMEN_BIT];
      bank_mode <= (MODE == MODE_MBC1) & savestate_data[SS_MODE_BIT];
    end else if (commit) begin
      rom_bank  <= rom_next;
      ram_bank  <= ram_next;
      ram_en    <= en_next;
      bank_mode <= mode_next;
    end
  end

  // Address mapping for ROM (fixed/switchable windows) and cart RAM
  always_comb begin
    lo16      = (MODE == MODE_MBC1 && bank_mode) ? {9'h000, bank2, 5'h00} : 16'h0000;
    hi16      = (MODE == MODE_MBC1) ? {9'h000, bank2, rb16[4:0]} : rb16;
    rom_sel16 = bus.cart_addr[14] ? hi16 : lo16;
    rb8       = (MODE == MODE_MBC1) ? (bank_mode ? {6'h00, bank2} : 8'h00) : 8'(ram_bank);
    if (RUMBLE != 0) rb8[3] = 1'b0;
  end

  assign mbc_addr    = {ROM_BANK_W'(rom_sel16) & rom_mask, bus.cart_addr[13:0]};
  assign cram_addr   = {RAM_BANK_W'(rb8) & ram_mask, bus.cart_addr[12:0]};
  assign ram_enabled = ram_en & has_ram;
  assign rumbling    = (RUMBLE != 0) && (MODE == MODE_MBC5) && ram_en &&
                       (|(8'(ram_bank) & 8'h08));

  assign savestate_back = {6'h00, bank_mode, ram_en, 8'(ram_bank), 16'(rom_bank)};

endmodule

// File: tb/tb_gb_mbc_bank_ctrl.sv
// Bench for gb_mbc_bank_ctrl: three instances (MBC5, MBC1, MBC5+rumble)
// share one CPU bus. Directed vector table, hand-written corner sequences,
// then random writes/savestates checked against a behavioural model.
module tb_gb_mbc_bank_ctrl;
  import gb_mbc_pkg::*;

  localparam int RW = 9;
  localparam int AW = 4;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [RW-1:0] rom_mask;
  logic [AW-1:0] ram_mask;
  logic          has_ram;
  logic          ss_load;
  logic [31:0]   ss_data;

  logic [31:0]   ss_back [ND];
  logic [22:0]   mbc     [ND];
  logic [16:0]   cram    [ND];
  logic          ren     [ND];
  logic          rumb    [ND];
  logic          ack     [ND];

  gb_mbc_bank_ctrl_if bus ();

  gb_mbc_bank_ctrl #(.ROM_BANK_W(RW), .RAM_BANK_W(AW), .MODE(0), .RUMBLE(0)) u_mbc5 (
    .clk_sys(clk), .reset_n(reset_n), .bus(bus), .rom_mask(rom_mask), .ram_mask(ram_mask),
    .has_ram(has_ram), .savestate_load(ss_load), .savestate_data(ss_data),
    .savestate_back(ss_back[0]), .mbc_addr(mbc[0]), .cram_addr(cram[0]),
    .ram_enabled(ren[0]), .rumbling(rumb[0]), .wr_ack(ack[0]));

  gb_mbc_bank_ctrl #(.ROM_BANK_W(RW), .RAM_BANK_W(AW), .MODE(1), .RUMBLE(0)) u_mbc1 (
    .clk_sys(clk), .reset_n(reset_n), .bus(bus), .rom_mask(rom_mask), .ram_mask(ram_mask),
    .has_ram(has_ram), .savestate_load(ss_load), .savestate_data(ss_data),
    .savestate_back(ss_back[1]), .mbc_addr(mbc[1]), .cram_addr(cram[1]),
    .ram_enabled(ren[1]), .rumbling(rumb[1]), .wr_ack(ack[1]));

  gb_mbc_bank_ctrl #(.ROM_BANK_W(RW), .RAM_BANK_W(AW), .MODE(0), .RUMBLE(1)) u_rumble (
    .clk_sys(clk), .reset_n(reset_n), .bus(bus), .rom_mask(rom_mask), .ram_mask(ram_mask),
    .has_ram(has_ram), .savestate_load(ss_load), .savestate_data(ss_data),
    .savestate_back(ss_back[2]), .mbc_addr(mbc[2]), .cram_addr(cram[2]),
    .ram_enabled(ren[2]), .rumbling(rumb[2]), .wr_ack(ack[2]));

  // ---------------- reference model ----------------
  int unsigned k_mode [ND] = '{0, 1, 0};
  int unsigned k_rum  [ND] = '{0, 0, 1};
  int unsigned m_rom  [ND];
  int unsigned m_ram  [ND];
  int unsigned m_en   [ND];
  int unsigned m_bm   [ND];
  int          ack_cnt[ND];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      m_rom[k] = 1; m_ram[k] = 0; m_en[k] = 0; m_bm[k] = 0;
    end
  endtask

  task automatic model_write(input int unsigned a, input int unsigned d);
    int unsigned v;
    for (int k = 0; k < ND; k++) begin
      case ((a >> 13) & 3)
        0: m_en[k] = ((d & 15) == 10) ? 1 : 0;
        1: begin
          if (k_mode[k] == 1) begin
            v = d & 31;
            if (v == 0) v = 1;
            m_rom[k] = (m_rom[k] & 'h1E0) | v;
          end else if ((a >> 12) & 1) begin
            m_rom[k] = (m_rom[k] & 'hFF) | ((d & 1) << 8);
          end else begin
            m_rom[k] = (m_rom[k] & 'h100) | d;
          end
        end
        2: m_ram[k] = (k_mode[k] == 1) ? ((m_ram[k] & 'hC) | (d & 3)) : (d & 15);
        default: if (k_mode[k] == 1) m_bm[k] = d & 1;
      endcase
    end
  endtask

  task automatic model_load(input logic [31:0] d);
    for (int k = 0; k < ND; k++) begin
      m_rom[k] = d & 'h1FF;
      m_ram[k] = (d >> 16) & 15;
      m_en[k]  = d[24];
      m_bm[k]  = (k_mode[k] == 1) ? d[25] : 0;
    end
  endtask

  function automatic int unsigned exp_mbc(input int k, input int unsigned a);
    int unsigned b2, bank;
    b2 = m_ram[k] & 3;
    if ((a >> 14) & 1) bank = (k_mode[k] == 1) ? (b2 * 32 + (m_rom[k] & 31)) : m_rom[k];
    else               bank = (k_mode[k] == 1 && m_bm[k] != 0) ? b2 * 32 : 0;
    return (bank & rom_mask) * 16384 + (a % 16384);
  endfunction

  function automatic int unsigned exp_cram(input int k, input int unsigned a);
    int unsigned rb;
    rb = (k_mode[k] == 1) ? ((m_bm[k] != 0) ? (m_ram[k] & 3) : 0) : m_ram[k];
    if (k_rum[k] != 0) rb = rb & 7;
    return (rb & ram_mask) * 8192 + (a % 8192);
  endfunction

  function automatic int unsigned exp_back(input int k);
    return m_rom[k] | (m_ram[k] << 16) | (m_en[k] << 24) | (m_bm[k] << 25);
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) ack_cnt[k] += int'(ack[k]);
  endtask

  task automatic clear_acks();
    for (int k = 0; k < ND; k++) ack_cnt[k] = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; bus.cart_wr = 1'b0; bus.ce = 1'b1; ss_load = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic do_write(input int unsigned a, input bit a15, input int unsigned d,
                          input int len, input bit rand_ce);
    bit done = 0;
    bus.cart_wr = 1'b0; bus.ce = 1'b1;
    tick();
    clear_acks();
    for (int c = 0; c < len; c++) begin
      bus.cart_addr = 15'(a); bus.cart_a15 = a15; bus.cart_di = 8'(d); bus.cart_wr = 1'b1;
      bus.ce = rand_ce ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (c == len - 1 && !done) bus.ce = 1'b1;
      tick();
      if (bus.ce && !done) begin
        done = 1;
        if (!a15) model_write(a, d);
      end
    end
    bus.cart_wr = 1'b0; bus.ce = 1'b1; bus.cart_a15 = 1'b0;
    tick(); tick();
    for (int k = 0; k < ND; k++)
      chk($sformatf("wr_ack_count[%0d]", k), 32'(ack_cnt[k]), a15 ? 32'd0 : 32'd1);
  endtask

  task automatic probe(input int unsigned a);
    bus.cart_wr = 1'b0; bus.cart_addr = 15'(a);
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("mbc_addr[%0d]@%0h", k, a), 32'(mbc[k]), exp_mbc(k, a));
      chk($sformatf("cram_addr[%0d]@%0h", k, a), 32'(cram[k]), exp_cram(k, a));
      chk($sformatf("ram_enabled[%0d]", k), 32'(ren[k]), 32'(m_en[k] & 32'(has_ram)));
      chk($sformatf("rumbling[%0d]", k), 32'(rumb[k]),
          32'((k_rum[k] != 0 && (m_ram[k] & 8) != 0 && m_en[k] != 0) ? 1 : 0));
      chk($sformatf("savestate_back[%0d]", k), ss_back[k], exp_back(k));
    end
  endtask

  // ---------------- directed vector table (checked on the MBC5 instance) ----------------
  typedef struct {
    logic [14:0] wa;
    logic        a15;
    logic [7:0]  wd;
    logic [14:0] pa;
    logic [22:0] e_mbc;
    logic [16:0] e_cram;
    logic        e_ren;
  } vec_t;

  vec_t tv [8];

  logic [14:0] ra;

  initial begin
    tv[0] = '{15'h2000, 1'b0, 8'h5A, 15'h4123, 23'h168123, 17'h00123, 1'b0};
    tv[1] = '{15'h3000, 1'b0, 8'h01, 15'h4123, 23'h568123, 17'h00123, 1'b0};
    tv[2] = '{15'h4000, 1'b0, 8'h05, 15'h2010, 23'h002010, 17'h0A010, 1'b0};
    tv[3] = '{15'h0000, 1'b0, 8'h0A, 15'h2010, 23'h002010, 17'h0A010, 1'b1};
    tv[4] = '{15'h6000, 1'b0, 8'hFF, 15'h7FFF, 23'h56BFFF, 17'h0BFFF, 1'b1};
    tv[5] = '{15'h0000, 1'b1, 8'h00, 15'h7FFF, 23'h56BFFF, 17'h0BFFF, 1'b1};
    tv[6] = '{15'h2000, 1'b0, 8'h00, 15'h4000, 23'h400000, 17'h0A000, 1'b1};
    tv[7] = '{15'h0000, 1'b0, 8'h0B, 15'h0001, 23'h000001, 17'h0A001, 1'b0};

    bus.ce = 1'b1; bus.cart_addr = '0; bus.cart_a15 = 1'b0; bus.cart_wr = 1'b0; bus.cart_di = '0;
    rom_mask = 9'h1FF; ram_mask = 4'hF; has_ram = 1'b1; ss_load = 1'b0; ss_data = '0;
    clear_acks();
    do_reset();

    // reset state
    bus.cart_addr = 15'h4000;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("reset_mbc[%0d]", k), 32'(mbc[k]), 32'h4000);
      chk($sformatf("reset_ren[%0d]", k), 32'(ren[k]), 32'd0);
      chk($sformatf("reset_rumb[%0d]", k), 32'(rumb[k]), 32'd0);
      chk($sformatf("reset_ack[%0d]", k), 32'(ack[k]), 32'd0);
      chk($sformatf("reset_back[%0d]", k), ss_back[k], 32'h1);
    end

    // directed table
    foreach (tv[i]) begin
      do_write(32'(tv[i].wa), tv[i].a15, 32'(tv[i].wd), $urandom_range(1, 10), 1'b1);
      bus.cart_addr = tv[i].pa;
      #1;
      chk($sformatf("tv%0d_mbc", i), 32'(mbc[0]), 32'(tv[i].e_mbc));
      chk($sformatf("tv%0d_cram", i), 32'(cram[0]), 32'(tv[i].e_cram));
      chk($sformatf("tv%0d_ren", i), 32'(ren[0]), 32'(tv[i].e_ren));
      probe(32'(tv[i].pa));
    end

    // ten-ce strobe yields exactly one ack (checked inside do_write)
    do_write(32'h2000, 1'b0, 32'h33, 10, 1'b0);
    probe(32'h4ABC);

    // MBC1 register map
    do_reset();
    do_write(32'h2000, 1'b0, 32'h00, 3, 1'b0);
    chk("mbc1_zero_as_one", ss_back[1], 32'h1);
    do_write(32'h4000, 1'b0, 32'h02, 2, 1'b0);
    do_write(32'h6000, 1'b0, 32'h01, 2, 1'b0);
    bus.cart_addr = 15'h0010;
    #1;
    chk("mbc1_bank0_window", 32'(mbc[1]), 32'h100010);
    bus.cart_addr = 15'h2000;
    #1;
    chk("mbc1_cram", 32'(cram[1]), 32'h04000);
    probe(32'h0010);
    probe(32'h2000);

    // rumble variant
    do_reset();
    do_write(32'h0000, 1'b0, 32'h0A, 2, 1'b0);
    do_write(32'h4000, 1'b0, 32'h0B, 2, 1'b0);
    bus.cart_addr = 15'h2000;
    #1;
    chk("rumble_on", 32'(rumb[2]), 32'd1);
    chk("rumble_cram_bank3", 32'(cram[2]), 32'h06000);
    do_write(32'h0000, 1'b0, 32'h00, 2, 1'b0);
    chk("rumble_off", 32'(rumb[2]), 32'd0);
    chk("rumble_ren_off", 32'(ren[2]), 32'd0);
    probe(32'h2000);

    // savestate load coincident with a commit
    bus.cart_wr = 1'b0; bus.ce = 1'b1;
    tick();
    clear_acks();
    bus.cart_addr = 15'h2000; bus.cart_di = 8'h55; bus.cart_wr = 1'b1;
    ss_load = 1'b1; ss_data = 32'h0300_00C7;
    tick();
    model_load(32'h0300_00C7);
    ss_load = 1'b0; bus.cart_wr = 1'b0;
    tick(); tick();
    for (int k = 0; k < ND; k++)
      chk($sformatf("ss_no_ack[%0d]", k), 32'(ack_cnt[k]), 32'd0);
    chk("ss_back_mbc1", ss_back[1], 32'h0300_00C7);
    probe(32'h4000);

    // reset mid-strobe: held strobe must not commit after release
    do_write(32'h0000, 1'b0, 32'h00, 1, 1'b0);
    bus.cart_addr = 15'h0000; bus.cart_di = 8'h0A; bus.cart_wr = 1'b1; bus.ce = 1'b1;
    tick();
    model_write(32'h0000, 32'h0A);
    reset_n = 1'b0;
    #2;
    model_reset();
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("async_rst_ren[%0d]", k), 32'(ren[k]), 32'd0);
      chk($sformatf("async_rst_back[%0d]", k), ss_back[k], 32'h1);
    end
    tick(); tick();
    reset_n = 1'b1;
    clear_acks();
    for (int c = 0; c < 4; c++) tick();
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("held_no_ack[%0d]", k), 32'(ack_cnt[k]), 32'd0);
      chk($sformatf("held_ren[%0d]", k), 32'(ren[k]), 32'd0);
    end
    do_write(32'h0000, 1'b0, 32'h0A, 2, 1'b0);
    probe(32'h1234);

    // random writes and savestates against the model
    for (int it = 0; it < 60; it++) begin
      if (it % 8 == 0) begin
        case ($urandom_range(0, 3))
          0: rom_mask = 9'h1FF;
          1: rom_mask = 9'h0FF;
          2: rom_mask = 9'h03F;
          default: rom_mask = 9'h007;
        endcase
        ram_mask = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h3;
        has_ram  = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        bus.cart_wr = 1'b0; bus.ce = 1'b1;
        tick();
        ss_load = 1'b1; ss_data = $urandom;
        tick();
        model_load(ss_data);
        ss_load = 1'b0;
      end else begin
        int unsigned a, d;
        a = $urandom_range(0, 32767);
        d = $urandom_range(0, 255);
        if (((a >> 13) & 3) == 0 && $urandom_range(0, 1) != 0) d = (d & 'hF0) | 'hA;
        do_write(a, ($urandom_range(0, 9) == 0), d, $urandom_range(1, 6), 1'b1);
      end
      ra = 15'($urandom_range(0, 32767));
      probe(32'(ra));
      probe(32'(ra ^ 15'h4000));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
